// File: rtl/spi_byte_master_pkg.sv
// spi_byte_master_pkg
//   Shared constants for the SPI byte master: default transfer width,
//   default SCLK half-period, FSM state encodings and a counter-width helper.
//   No ports; imported by spi_byte_master and spi_clkgen.

package spi_byte_master_pkg;

  // Default transfer width in bits.
  localparam int SPI_LEN = 8;

  // Default SCLK half-period, in clk_in cycles.
  localparam int SPI_CLKDIV_DEFAULT = 4;

  // FSM state encodings (plain constants so legacy tooling can decode them).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Counter width for a counter that must reach max_count: $clog2(n)+1 bits.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen
//   Half-period timebase and SCLK level generator for spi_byte_master.
//   While en is high a divider counts clk_in cycles; tick pulses on the last
//   cycle of each half-period. On a tick with toggle high, sclk inverts.
//   In hold_mode the divider runs one count longer (CLKDIV+1 cycles), which
//   covers the cycle carrying rx_valid plus a full CLKDIV guard period.
//   Dropping en clears the divider and parks sclk low.
//
//   Ports
//     clk_in     in   system clock, rising edge
//     rst        in   asynchronous active-high reset
//     en         in   run the divider (FSM not IDLE)
//     hold_mode  in   use the extended CS hold period
//     toggle     in   allow sclk to invert on this tick
//     tick       out  last cycle of the current period
//     sclk       out  registered SCLK level (mode 0, idles low)

module spi_clkgen
  import spi_byte_master_pkg::*;
#(
  parameter int CLKDIV = SPI_CLKDIV_DEFAULT
) (
  input  logic clk_in,
  input  logic rst,
  input  logic en,
  input  logic hold_mode,
  input  logic toggle,
  output logic tick,
  output logic sclk
);

  localparam int DW = cnt_width(CLKDIV);
  localparam logic [DW-1:0] HALF_LAST = DW'(CLKDIV - 1);
  localparam logic [DW-1:0] HOLD_LAST = DW'(CLKDIV);

  if (CLKDIV < 1) begin : g_bad_clkdiv
    $fatal(1, "spi_clkgen: CLKDIV must be at least 1");
  end

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] limit;

  assign limit = hold_mode ? HOLD_LAST : HALF_LAST;
  assign tick  = en && (div_cnt == limit);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      if (toggle) begin
        sclk <= ~sclk;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_byte_master.sv
// spi_byte_master
//   Single-byte SPI mode-0 master with per-transfer chip-select mask and
//   optional CS hold between bytes.
//
//   Handshake: a request is accepted in any cycle where tx_valid and
//   tx_ready are both high; tx_data, cs_mask and hold_cs are captured in that
//   cycle only. tx_ready is high exactly when the FSM is IDLE. rx_valid is a
//   one-cycle pulse with no back-pressure; rx_data holds until the next pulse.
//
//   Timeline for a handshake in cycle T (C = CLKDIV, L = LEN):
//     T+1            CS = ~cs_mask, MOSI = first bit, SETUP (C cycles, SCLK low)
//     T+1+C          SHIFT: L periods of C high + C low cycles
//     T+1+(2L+1)C    rx_valid; then HOLD (CS kept) or IDLE (CS held by hold_cs)
//
//   Ports
//     clk_in      in   system clock, rising edge
//     rst         in   asynchronous active-high reset
//     tx_valid    in   transfer request
//     tx_ready    out  FSM is IDLE and can accept a request
//     tx_data     in   byte to send, MSB first
//     cs_mask     in   lines to select (1 = select)
//     hold_cs     in   keep CS asserted after this byte
//     cs_release  in   pulse in IDLE to deassert a held CS
//     rx_valid    out  one-cycle pulse, rx_data valid
//     rx_data     out  last received byte
//     busy        out  FSM is not IDLE
//     MISO        in   serial data from slave
//     MOSI        out  serial data to slave
//     SCLK        out  serial clock, idles low
//     CS          out  active-low chip selects
//     state_dbg   out  current FSM state encoding

module spi_byte_master
  import spi_byte_master_pkg::*;
#(
  parameter int LEN    = SPI_LEN,
  parameter int IONUM  = 1,
  parameter int CLKDIV = SPI_CLKDIV_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [LEN-1:0]   tx_data,
  input  logic [IONUM-1:0] cs_mask,
  input  logic             hold_cs,
  input  logic             cs_release,
  output logic             rx_valid,
  output logic [LEN-1:0]   rx_data,
  output logic             busy,
  input  logic             MISO,
  output logic             MOSI,
  output logic             SCLK,
  output logic [IONUM-1:0] CS,
  output logic [1:0]       state_dbg
);

  localparam int BW = cnt_width(LEN);
  localparam logic [BW-1:0] BITS_ALL  = BW'(LEN);
  localparam logic [BW-1:0] LAST_FALL = BW'(LEN - 1);

  if (CLKDIV < 1) begin : g_bad_clkdiv
    $fatal(1, "spi_byte_master: CLKDIV must be at least 1");
  end
  if (LEN < 2) begin : g_bad_len
    $fatal(1, "spi_byte_master: LEN must be at least 2");
  end

  logic [1:0]     state;
  logic [1:0]     state_nxt;
  logic [LEN-1:0] tx_shift;
  logic [LEN-1:0] rx_shift;
  logic [BW-1:0]  bit_cnt;   // falling edges completed in this transfer
  logic           hold_lat;

  logic tick;
  logic clk_en;
  logic hold_mode;
  logic toggle;
  logic last_low;
  logic rise_evt;
  logic fall_evt;
  logic end_evt;

  assign tx_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  assign clk_en    = (state != ST_IDLE);
  assign hold_mode = (state == ST_HOLD);

  // The final low phase follows the LEN-th falling edge; its tick ends the
  // shift and must not raise SCLK again.
  assign last_low = (state == ST_SHIFT) && !SCLK && (bit_cnt == BITS_ALL);
  assign toggle   = (state == ST_SETUP) || ((state == ST_SHIFT) && !last_low);

  // Edge events are the ticks on which the registered SCLK will change.
  // The end of SETUP is the first rising edge.
  assign rise_evt = tick && !SCLK &&
                    ((state == ST_SETUP) ||
                     ((state == ST_SHIFT) && (bit_cnt != BITS_ALL)));
  assign fall_evt = tick && SCLK && (state == ST_SHIFT);
  assign end_evt  = tick && last_low;

  spi_clkgen #(
    .CLKDIV(CLKDIV)
  ) u_clkgen (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (clk_en),
    .hold_mode(hold_mode),
    .toggle   (toggle),
    .tick     (tick),
    .sclk     (SCLK)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (end_evt) begin
          state_nxt = hold_lat ? ST_IDLE : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      hold_lat <= 1'b0;
      MOSI     <= 1'b0;
      CS       <= '1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      state    <= state_nxt;
      rx_valid <= 1'b0;

      // MISO is sampled directly; the slave holds it stable across the
      // rising edge, which is at least one clk_in cycle after it changed.
      if (rise_evt) begin
        rx_shift <= {rx_shift[LEN-2:0], MISO};
      end

      case (state)
        ST_IDLE: begin
          // A request wins over a coinciding cs_release; switching straight
          // to the new mask leaves no deassert gap on a held CS.
          if (tx_valid) begin
            tx_shift <= {tx_data[LEN-2:0], 1'b0};
            MOSI     <= tx_data[LEN-1];
            CS       <= ~cs_mask;
            hold_lat <= hold_cs;
            bit_cnt  <= '0;
          end else if (cs_release) begin
            CS <= '1;
          end
        end
        ST_SHIFT: begin
          if (fall_evt) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt != LAST_FALL) begin
              MOSI     <= tx_shift[LEN-1];
              tx_shift <= {tx_shift[LEN-2:0], 1'b0};
            end
          end
          if (end_evt) begin
            rx_valid <= 1'b1;
            rx_data  <= rx_shift;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            CS <= '1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master.
//   dut_a: LEN=8, IONUM=2, CLKDIV=2, MISO looped back from MOSI.
//   dut_b: LEN=8, IONUM=1, CLKDIV=1, slave model returning 0xC3.

module tb_spi_byte_master;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  always #5 clk_in = ~clk_in;

  // dut_a signals
  logic       tx_valid_a   = 1'b0;
  logic       tx_ready_a;
  logic [7:0] tx_data_a    = 8'h00;
  logic [1:0] cs_mask_a    = 2'b00;
  logic       hold_cs_a    = 1'b0;
  logic       cs_release_a = 1'b0;
  logic       rx_valid_a;
  logic [7:0] rx_data_a;
  logic       busy_a;
  logic       miso_a;
  logic       mosi_a;
  logic       sclk_a;
  logic [1:0] cs_a;
  logic [1:0] state_a;

  assign miso_a = mosi_a;

  // dut_b signals
  logic       tx_valid_b   = 1'b0;
  logic       tx_ready_b;
  logic [7:0] tx_data_b    = 8'h00;
  logic [0:0] cs_mask_b    = 1'b0;
  logic       hold_cs_b    = 1'b0;
  logic       cs_release_b = 1'b0;
  logic       rx_valid_b;
  logic [7:0] rx_data_b;
  logic       busy_b;
  logic       miso_b;
  logic       mosi_b;
  logic       sclk_b;
  logic [0:0] cs_b;
  logic [1:0] state_b;

  // Mode-0 slave for dut_b: first bit valid once CS falls, next bit after
  // each SCLK falling edge.
  logic [7:0] slave_byte = 8'hC3;
  int         slv_cnt    = 0;

  always @(negedge sclk_b or posedge cs_b[0]) begin
    if (cs_b[0]) slv_cnt <= 0;
    else         slv_cnt <= slv_cnt + 1;
  end

  assign miso_b = (slv_cnt < 8) ? slave_byte[7 - slv_cnt] : 1'b0;

  spi_byte_master #(.LEN(8), .IONUM(2), .CLKDIV(2)) dut_a (
    .clk_in    (clk_in),
    .rst       (rst),
    .tx_valid  (tx_valid_a),
    .tx_ready  (tx_ready_a),
    .tx_data   (tx_data_a),
    .cs_mask   (cs_mask_a),
    .hold_cs   (hold_cs_a),
    .cs_release(cs_release_a),
    .rx_valid  (rx_valid_a),
    .rx_data   (rx_data_a),
    .busy      (busy_a),
    .MISO      (miso_a),
    .MOSI      (mosi_a),
    .SCLK      (sclk_a),
    .CS        (cs_a),
    .state_dbg (state_a)
  );

  spi_byte_master #(.LEN(8), .IONUM(1), .CLKDIV(1)) dut_b (
    .clk_in    (clk_in),
    .rst       (rst),
    .tx_valid  (tx_valid_b),
    .tx_ready  (tx_ready_b),
    .tx_data   (tx_data_b),
    .cs_mask   (cs_mask_b),
    .hold_cs   (hold_cs_b),
    .cs_release(cs_release_b),
    .rx_valid  (rx_valid_b),
    .rx_data   (rx_data_b),
    .busy      (busy_b),
    .MISO      (miso_b),
    .MOSI      (mosi_b),
    .SCLK      (sclk_b),
    .CS        (cs_b),
    .state_dbg (state_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Observes dut_a for ncyc cycles, k=1 being the cycle after the handshake.
  task automatic mon_a(input int ncyc, output int rx_k, output int rx_n,
                       output logic [7:0] rx_d, output int cs_low,
                       output logic [7:0] mosi_bits, output logic [1:0] cs_first);
    logic prev_sclk;
    prev_sclk = 1'b0;
    rx_k = 0; rx_n = 0; rx_d = 8'h00; cs_low = 0; mosi_bits = 8'h00; cs_first = 2'b00;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk_in);
      if (k == 1) cs_first = cs_a;
      if (cs_a != 2'b11) cs_low++;
      if (rx_valid_a) begin
        rx_n++;
        if (rx_k == 0) rx_k = k;
        rx_d = rx_data_a;
      end
      if (sclk_a && !prev_sclk) mosi_bits = {mosi_bits[6:0], mosi_a};
      prev_sclk = sclk_a;
    end
  endtask

  task automatic mon_b(input int ncyc, output int rx_k, output int rx_n,
                       output logic [7:0] rx_d, output int cs_low,
                       output logic [7:0] mosi_bits);
    logic prev_sclk;
    prev_sclk = 1'b0;
    rx_k = 0; rx_n = 0; rx_d = 8'h00; cs_low = 0; mosi_bits = 8'h00;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk_in);
      if (cs_b[0] == 1'b0) cs_low++;
      if (rx_valid_b) begin
        rx_n++;
        if (rx_k == 0) rx_k = k;
        rx_d = rx_data_b;
      end
      if (sclk_b && !prev_sclk) mosi_bits = {mosi_bits[6:0], mosi_b};
      prev_sclk = sclk_b;
    end
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         rx_k, rx_n, cs_low, rises, rise5_k;
    logic [7:0] rx_d, mosi_bits;
    logic [1:0] cs_first;
    logic       prev_sclk;

    // Reset values
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_cs_a",       cs_a, 2'b11);
    check("rst_sclk_a",     sclk_a, 1'b0);
    check("rst_mosi_a",     mosi_a, 1'b0);
    check("rst_rx_valid_a", rx_valid_a, 1'b0);
    check("rst_rx_data_a",  rx_data_a, 8'h00);
    check("rst_busy_a",     busy_a, 1'b0);
    check("rst_state_a",    state_a, 2'd0);
    check("rst_cs_b",       cs_b, 1'b1);
    check("rst_busy_b",     busy_b, 1'b0);
    check("rst_state_b",    state_b, 2'd0);
    rst = 1'b0;
    @(negedge clk_in);
    check("post_rst_ready_a", tx_ready_a, 1'b1);
    check("post_rst_ready_b", tx_ready_b, 1'b1);

    // 0xA5 loopback, CLKDIV=2
    tx_data_a = 8'hA5; cs_mask_a = 2'b11; hold_cs_a = 1'b0; tx_valid_a = 1'b1;
    step();
    tx_valid_a = 1'b0;
    check("a5_busy",  busy_a, 1'b1);
    check("a5_ready", tx_ready_a, 1'b0);
    mon_a(60, rx_k, rx_n, rx_d, cs_low, mosi_bits, cs_first);
    check("a5_rx_cycle", rx_k, 35);
    check("a5_rx_count", rx_n, 1);
    check("a5_rx_data",  rx_d, 8'hA5);
    check("a5_cs_low",   cs_low, 37);
    check("a5_cs_first", cs_first, 2'b00);
    check("a5_mosi",     mosi_bits, 8'hA5);
    check("a5_cs_end",   cs_a, 2'b11);
    check("a5_idle",     busy_a, 1'b0);
    repeat (3) @(negedge clk_in);
    check("a5_rx_hold",  rx_data_a, 8'hA5);

    // 0x3C out, 0xC3 back, CLKDIV=1
    tx_data_b = 8'h3C; cs_mask_b = 1'b1; hold_cs_b = 1'b0; tx_valid_b = 1'b1;
    step();
    tx_valid_b = 1'b0;
    mon_b(30, rx_k, rx_n, rx_d, cs_low, mosi_bits);
    check("b_rx_cycle", rx_k, 18);
    check("b_rx_count", rx_n, 1);
    check("b_rx_data",  rx_d, 8'hC3);
    check("b_mosi",     mosi_bits, 8'h3C);
    check("b_cs_low",   cs_low, 19);
    check("b_cs_end",   cs_b, 1'b1);

    // Held CS across two back-to-back bytes, then cs_release
    @(negedge clk_in);
    tx_data_a = 8'h01; cs_mask_a = 2'b11; hold_cs_a = 1'b1; tx_valid_a = 1'b1;
    step();
    tx_valid_a = 1'b0;
    mon_a(35, rx_k, rx_n, rx_d, cs_low, mosi_bits, cs_first);
    check("hold1_rx_cycle", rx_k, 35);
    check("hold1_rx_data",  rx_d, 8'h01);
    check("hold1_cs_low",   cs_low, 35);
    check("hold1_ready",    tx_ready_a, 1'b1);
    tx_data_a = 8'h02; tx_valid_a = 1'b1;
    step();
    tx_valid_a = 1'b0;
    mon_a(40, rx_k, rx_n, rx_d, cs_low, mosi_bits, cs_first);
    check("hold2_rx_cycle", rx_k, 35);
    check("hold2_rx_data",  rx_d, 8'h02);
    check("hold2_cs_low",   cs_low, 40);
    check("hold2_cs_kept",  cs_a, 2'b00);
    cs_release_a = 1'b1;
    step();
    cs_release_a = 1'b0;
    @(negedge clk_in);
    check("release_cs", cs_a, 2'b11);

    // Mask 2'b10 held, then mask 2'b01 with a coinciding cs_release
    tx_data_a = 8'h5A; cs_mask_a = 2'b10; hold_cs_a = 1'b1; tx_valid_a = 1'b1;
    step();
    tx_valid_a = 1'b0;
    mon_a(40, rx_k, rx_n, rx_d, cs_low, mosi_bits, cs_first);
    check("m10_cs_first", cs_first, 2'b01);
    check("m10_rx_data",  rx_d, 8'h5A);
    check("m10_cs_held",  cs_a, 2'b01);
    tx_data_a = 8'hC3; cs_mask_a = 2'b01; hold_cs_a = 1'b1;
    tx_valid_a = 1'b1; cs_release_a = 1'b1;
    step();
    tx_valid_a = 1'b0; cs_release_a = 1'b0;
    check("m01_cs_t1", cs_a, 2'b10);
    check("m01_busy",  busy_a, 1'b1);
    mon_a(40, rx_k, rx_n, rx_d, cs_low, mosi_bits, cs_first);
    check("m01_cs_low",  cs_low, 40);
    check("m01_rx_data", rx_d, 8'hC3);
    check("m01_cs_held", cs_a, 2'b10);

    // All-zero mask: no line selected, transfer still completes
    tx_data_a = 8'h7E; cs_mask_a = 2'b00; hold_cs_a = 1'b0; tx_valid_a = 1'b1;
    step();
    tx_valid_a = 1'b0;
    mon_a(60, rx_k, rx_n, rx_d, cs_low, mosi_bits, cs_first);
    check("m00_cs_first", cs_first, 2'b11);
    check("m00_cs_low",   cs_low, 0);
    check("m00_rx_count", rx_n, 1);
    check("m00_rx_cycle", rx_k, 35);
    check("m00_rx_data",  rx_d, 8'h7E);

    // Reset at the 5th SCLK rise
    tx_data_a = 8'hFF; cs_mask_a = 2'b11; hold_cs_a = 1'b0; tx_valid_a = 1'b1;
    step();
    tx_valid_a = 1'b0;
    rises = 0; rise5_k = 0; prev_sclk = 1'b0;
    for (int k = 1; k <= 40 && rises < 5; k++) begin
      @(negedge clk_in);
      if (sclk_a && !prev_sclk) rises++;
      if (rises == 5) rise5_k = k;
      prev_sclk = sclk_a;
    end
    check("rst5_rise_cycle", rise5_k, 19);
    rst = 1'b1;
    #1;
    check("rst5_cs",       cs_a, 2'b11);
    check("rst5_sclk",     sclk_a, 1'b0);
    check("rst5_busy",     busy_a, 1'b0);
    check("rst5_rx_valid", rx_valid_a, 1'b0);
    @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    check("rst5_ready", tx_ready_a, 1'b1);
    mon_a(40, rx_k, rx_n, rx_d, cs_low, mosi_bits, cs_first);
    check("rst5_no_rx",  rx_n, 0);
    check("rst5_cs_off", cs_low, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
